calc_sequencer: RTL

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// Keypad-driven sequencer for a calculator ALU: collects hex digits, loads operands, runs one-cycle EXEC.
// Optional macro CALC_CHAIN_EN: EXEC cycle also loads in1 with the ALU result (result chaining).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_ENTRY  | accepting digits into entry; disp shows entry
// S_EXEC   | single cycle capturing alu_out/alu_fout; key events dropped
// S_RESULT | showing captured result; a digit starts a fresh entry
module calc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe,
  input  logic [4:0]  key,
  input  logic [31:0] alu_out,
  input  logic [3:0]  alu_fout,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [4:0]  op,
  output logic [3:0]  fin,
  output logic [31:0] disp,
  output logic        busy
);

  typedef enum logic [1:0] {S_ENTRY, S_EXEC, S_RESULT} state_t;

  localparam logic [4:0] KEY_LD1    = 5'd16;
  localparam logic [4:0] KEY_LD2    = 5'd17;
  localparam logic [4:0] KEY_OPNEXT = 5'd18;
  localparam logic [4:0] KEY_EXEC   = 5'd19;
  localparam logic [4:0] OP_LAST    = 5'd19;

  state_t      state_q, state_d;
  logic        strobe_prev_q, strobe_prev_d;
  logic [31:0] entry_q, entry_d;
  logic [31:0] result_q, result_d;
  logic [31:0] in1_q, in1_d;
  logic [31:0] in2_q, in2_d;
  logic [4:0]  op_q, op_d;
  logic [3:0]  fin_q, fin_d;
  logic [31:0] disp_q, disp_d;
  logic        busy_q, busy_d;
  logic        key_ev;

  always_comb begin
    state_d       = state_q;
    strobe_prev_d = strobe;
    entry_d       = entry_q;
    result_d      = result_q;
    in1_d         = in1_q;
    in2_d         = in2_q;
    op_d          = op_q;
    fin_d         = fin_q;
    key_ev        = strobe & ~strobe_prev_q;

    case (state_q)
      S_ENTRY, S_RESULT: begin
        if (key_ev) begin
          if (key < 5'd16) begin
            if (state_q == S_ENTRY) entry_d = {entry_q[27:0], key[3:0]};
            else                    entry_d = {28'b0, key[3:0]};
            state_d = S_ENTRY;
          end else if (key == KEY_LD1) begin
            in1_d   = entry_q;
            entry_d = 32'b0;
            state_d = S_ENTRY;
          end else if (key == KEY_LD2) begin
            in2_d   = entry_q;
            entry_d = 32'b0;
            state_d = S_ENTRY;
          end else if (key == KEY_OPNEXT) begin
            op_d = (op_q == OP_LAST) ? 5'd0 : op_q + 5'd1;
          end else if (key == KEY_EXEC) begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        // Any strobe edge seen here is dropped; strobe_prev still tracks the line.
        result_d = alu_out;
        fin_d    = alu_fout;
`ifdef CALC_CHAIN_EN
        in1_d    = alu_out;
`else
        in1_d    = in1_q;
`endif
        state_d  = S_RESULT;
      end
      default: state_d = S_ENTRY;
    endcase

    busy_d = (state_d == S_EXEC);
    disp_d = (state_d == S_RESULT) ? result_d : entry_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_ENTRY;
      strobe_prev_q <= 1'b1;
      entry_q       <= 32'b0;
      result_q      <= 32'b0;
      in1_q         <= 32'b0;
      in2_q         <= 32'b0;
      op_q          <= 5'd0;
      fin_q         <= 4'b0;
      disp_q        <= 32'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      strobe_prev_q <= strobe_prev_d;
      entry_q       <= entry_d;
      result_q      <= result_d;
      in1_q         <= in1_d;
      in2_q         <= in2_d;
      op_q          <= op_d;
      fin_q         <= fin_d;
      disp_q        <= disp_d;
      busy_q        <= busy_d;
    end
  end

  assign in1  = in1_q;
  assign in2  = in2_q;
  assign op   = op_q;
  assign fin  = fin_q;
  assign disp = disp_q;
  assign busy = busy_q;

endmodule
